// File: rtl/fft16_r4_sequencer.sv
// rtl/fft16_r4_sequencer.sv - sample buffer and pass sequencer around the 16-point radix-4 butterfly
//
// Purpose: loads 16 complex samples into bank BA and drives the external
// combinational DFT4 butterfly through eight passes. Passes 0-3 go from BA to BB
// and passes 4-7 go from BB back to BA. It then streams X[0]..X[15] out of BA in
// natural order.
// Optional feature: define FFT16_STAGE_SCALE_EN to arithmetically shift every
// butterfly result component right by 2 before writeback. The output is then DFT/16.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      input sample handshake, in_re/in_im sample
//   out_valid/out_ready    output bin handshake, out_re/out_im bin, out_idx bin index
//   busy                   high while the butterfly passes run
//   calc_in                butterfly operands A,B,C,D (slot s at [2*DW*s +: 2*DW], re upper)
//   rotation               butterfly pass index 0..7
//   calc_out               butterfly results, slot k = DFT4 bin k, same packing
module fft16_r4_sequencer #(
  parameter int DW = 17
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_re,
  input  logic [DW-1:0]   in_im,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_re,
  output logic [DW-1:0]   out_im,
  output logic [3:0]      out_idx,
  output logic            busy,
  output logic [8*DW-1:0] calc_in,
  output logic [2:0]      rotation,
  input  logic [8*DW-1:0] calc_out
);

  typedef enum logic [1:0] {LOAD, STAGE1, STAGE2, UNLOAD} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;
  logic [2:0]      rotation_q, rotation_d;
  logic [3:0]      out_idx_q, out_idx_d;
  logic [2*DW-1:0] ba_q [16];
  logic [2*DW-1:0] ba_d [16];
  logic [2*DW-1:0] bb_q [16];
  logic [2*DW-1:0] bb_d [16];
  logic [1:0]      b;

  assign b = cnt_q[1:0];

  // Writeback conditioning of one {re,im} butterfly result.
  function automatic logic [2*DW-1:0] wb(input logic [2*DW-1:0] v);
`ifdef FFT16_STAGE_SCALE_EN
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
    re = $signed(v[2*DW-1:DW]) >>> 2;
    im = $signed(v[DW-1:0]) >>> 2;
    return {re, im};
`else
    return v;
`endif
  endfunction

  // Pass b of each stage reads entries b, b+4, b+8, b+12 of the source bank.
  always_comb begin
    calc_in = '0;
    if (state_q == STAGE1 || state_q == STAGE2) begin
      for (int s = 0; s < 4; s++) begin
        calc_in[2*DW*s +: 2*DW] = (state_q == STAGE1) ? ba_q[{2'(s), b}] : bb_q[{2'(s), b}];
      end
    end
  end

  // Natural-order output: bin k lives at BA[4*k[1:0] + k[3:2]].
  assign {out_re, out_im} = ba_q[{cnt_q[1:0], cnt_q[3:2]}];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ba_d    = ba_q;
    bb_d    = bb_q;
    case (state_q)
      LOAD: begin
        if (in_valid && in_ready_q) begin
          ba_d[cnt_q] = {in_re, in_im};
          cnt_d       = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            cnt_d   = '0;
            state_d = STAGE1;
          end
        end
      end
      STAGE1: begin
        for (int k = 0; k < 4; k++) begin
          bb_d[{b, 2'(k)}] = wb(calc_out[2*DW*k +: 2*DW]);
        end
        cnt_d = cnt_q + 4'd1;
        if (b == 2'd3) begin
          cnt_d   = '0;
          state_d = STAGE2;
        end
      end
      STAGE2: begin
        for (int k = 0; k < 4; k++) begin
          ba_d[{b, 2'(k)}] = wb(calc_out[2*DW*k +: 2*DW]);
        end
        cnt_d = cnt_q + 4'd1;
        if (b == 2'd3) begin
          cnt_d   = '0;
          state_d = UNLOAD;
        end
      end
      default: begin
        if (out_valid_q && out_ready) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            cnt_d   = '0;
            state_d = LOAD;
          end
        end
      end
    endcase

    // Outputs are registered, so they are derived from the next state.
    in_ready_d  = (state_d == LOAD);
    out_valid_d = (state_d == UNLOAD);
    busy_d      = (state_d == STAGE1) || (state_d == STAGE2);
    rotation_d  = '0;
    if (state_d == STAGE1) rotation_d = {1'b0, cnt_d[1:0]};
    if (state_d == STAGE2) rotation_d = {1'b1, cnt_d[1:0]};
    out_idx_d   = (state_d == UNLOAD) ? cnt_d : 4'd0;
  end

  always_ff @(posedge clk) begin
    // The banks hold no reset value, because a new frame overwrites every entry.
    ba_q <= ba_d;
    bb_q <= bb_d;
    if (rst) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      rotation_q  <= '0;
      out_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      rotation_q  <= rotation_d;
      out_idx_q   <= out_idx_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign rotation  = rotation_q;
  assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_fft16_r4_sequencer.sv
// tb/tb_fft16_r4_sequencer.sv - directed self-checking bench for fft16_r4_sequencer
//
// Purpose: drives frames through the sequencer. The butterfly is a bench model:
// either an identity stub (calc_out = calc_in) or a plain DFT4.
// Define FFT16_STAGE_SCALE_EN to match a scaled build of the design.
module tb_fft16_r4_sequencer;
  localparam int DW = 17;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_re, in_im;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_re, out_im;
  logic [3:0]      out_idx;
  logic            busy;
  logic [8*DW-1:0] calc_in;
  logic [2:0]      rotation;
  logic [8*DW-1:0] calc_out;

  logic bf_identity;
  int   cyc = 0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  int   acc_cyc, first_cyc;

  logic signed [DW-1:0] x_re [16];
  logic signed [DW-1:0] x_im [16];
  logic signed [DW-1:0] e_re [16];
  logic signed [DW-1:0] e_im [16];
  logic signed [DW-1:0] r_re [16];
  logic signed [DW-1:0] r_im [16];
  logic [3:0]           r_idx [16];

  fft16_r4_sequencer #(.DW(DW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_idx(out_idx), .busy(busy), .calc_in(calc_in), .rotation(rotation),
    .calc_out(calc_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Butterfly model: identity stub or an untwiddled DFT4, wrapping at DW bits.
  always_comb begin
    logic [DW-1:0] ar [4];
    logic [DW-1:0] ai [4];
    logic [DW-1:0] xr [4];
    logic [DW-1:0] xi [4];
    for (int s = 0; s < 4; s++) begin
      ar[s] = calc_in[2*DW*s+DW +: DW];
      ai[s] = calc_in[2*DW*s +: DW];
    end
    xr[0] = ar[0] + ar[1] + ar[2] + ar[3];
    xi[0] = ai[0] + ai[1] + ai[2] + ai[3];
    xr[1] = ar[0] + ai[1] - ar[2] - ai[3];
    xi[1] = ai[0] - ar[1] - ai[2] + ar[3];
    xr[2] = ar[0] - ar[1] + ar[2] - ar[3];
    xi[2] = ai[0] - ai[1] + ai[2] - ai[3];
    xr[3] = ar[0] - ai[1] - ar[2] + ai[3];
    xi[3] = ai[0] + ar[1] - ai[2] - ar[3];
    calc_out = '0;
    for (int k = 0; k < 4; k++) calc_out[2*DW*k +: 2*DW] = {xr[k], xi[k]};
    if (bf_identity) calc_out = calc_in;
  end

  // With the identity butterfly, bin k is x[4*(k%4) + k/4] (scaled by 1/16 when enabled).
  task automatic make_perm_expect();
    for (int k = 0; k < 16; k++) begin
      logic signed [DW-1:0] vr, vi;
      vr = x_re[4*(k%4) + k/4];
      vi = x_im[4*(k%4) + k/4];
`ifdef FFT16_STAGE_SCALE_EN
      vr = vr >>> 4;
      vi = vi >>> 4;
`endif
      e_re[k] = vr;
      e_im[k] = vi;
    end
  endtask

  task automatic make_impulse();
    for (int n = 0; n < 16; n++) begin
      x_re[n] = '0;
      x_im[n] = '0;
      e_re[n] = 17'sd100;
      e_im[n] = '0;
    end
`ifdef FFT16_STAGE_SCALE_EN
    x_re[0] = 17'sd1600;
`else
    x_re[0] = 17'sd100;
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int gap);
    for (int i = 0; i < 16; i++) begin
      int t;
      t = 0;
      while (!in_ready && t < 200) begin
        step();
        t++;
      end
      if (t >= 200) begin
        chk_cnt++;
        $display("FAIL send_timeout: sample %0d, in_ready stayed %b, required 1", i, in_ready);
        in_valid = 1'b0;
        return;
      end
      in_valid = 1'b1;
      in_re    = x_re[i];
      in_im    = x_im[i];
      step();
      if (i == 15) acc_cyc = cyc;
      in_valid = 1'b0;
      in_re    = 17'h1ABCD;
      in_im    = 17'h0BEEF;
      repeat (gap) step();
    end
  endtask

  // Collects 16 output handshakes. While stalled, it checks that the presented bin holds.
  task automatic recv_frame(input bit bp);
    int   got, tmo, j;
    bit   have_prev, seen;
    logic [DW-1:0] p_re, p_im;
    logic [3:0]    p_idx;
    got = 0; tmo = 0; j = 0; have_prev = 0; seen = 0;
    p_re = '0; p_im = '0; p_idx = '0;
    while (got < 16 && tmo < 300) begin
      out_ready = bp ? (j % 3 == 0) : 1'b1;
      if (out_valid) begin
        if (!seen) begin
          first_cyc = cyc;
          seen = 1;
        end
        if (have_prev) begin
          chk_cnt++;
          if ({out_re, out_im, out_idx} !== {p_re, p_im, p_idx})
            $display("FAIL stall_hold: got %h/%h idx %0d, required %h/%h idx %0d",
                     out_re, out_im, out_idx, p_re, p_im, p_idx);
          else pass_cnt++;
        end
        if (out_ready) begin
          r_re[got] = out_re; r_im[got] = out_im; r_idx[got] = out_idx;
          got++;
          have_prev = 0;
        end else begin
          p_re = out_re; p_im = out_im; p_idx = out_idx;
          have_prev = 1;
        end
      end
      j++;
      tmo++;
      step();
    end
    out_ready = 1'b0;
    if (got < 16) begin
      chk_cnt++;
      $display("FAIL recv_timeout: got %0d bins, required 16", got);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_re = '0; in_im = '0; bf_identity = 1'b1;
    repeat (3) step();
    chk_cnt++;
    if ({in_ready, out_valid, busy, rotation, out_idx} !== {1'b1, 1'b0, 1'b0, 3'd0, 4'd0})
      $display("FAIL reset_state: in_ready %b out_valid %b busy %b rot %0d idx %0d, required 1 0 0 0 0",
               in_ready, out_valid, busy, rotation, out_idx);
    else pass_cnt++;
    chk_cnt++;
    if (calc_in !== '0) $display("FAIL reset_calc_in: got %h, required 0", calc_in);
    else pass_cnt++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_permutation();
    bf_identity = 1'b1;
    for (int n = 0; n < 16; n++) begin
      x_re[n] = 17'(n);
      x_im[n] = -17'(n);
    end
    make_perm_expect();
    send_frame(0);
    recv_frame(0);
    for (int k = 0; k < 16; k++) begin
      chk_cnt++;
      if (r_re[k] !== e_re[k] || r_im[k] !== e_im[k] || r_idx[k] !== 4'(k))
        $display("FAIL perm_bin%0d: got (%0d,%0d) idx %0d, required (%0d,%0d) idx %0d",
                 k, r_re[k], r_im[k], r_idx[k], e_re[k], e_im[k], k);
      else pass_cnt++;
    end
    chk_cnt++;
    if (first_cyc - acc_cyc !== 8)
      $display("FAIL latency: got %0d edges, required 8", first_cyc - acc_cyc);
    else pass_cnt++;
  endtask

  task automatic test_passes();
    bf_identity = 1'b1;
    for (int n = 0; n < 16; n++) begin
      x_re[n] = 17'(10 + n);
      x_im[n] = 17'(50 + n);
    end
    chk_cnt++;
    if (rotation !== 3'd0 || calc_in !== '0 || busy !== 1'b0)
      $display("FAIL load_idle: rot %0d busy %b calc_in %h, required 0 0 0", rotation, busy, calc_in);
    else pass_cnt++;
    send_frame(0);
    for (int i = 0; i < 8; i++) begin
      chk_cnt++;
      if (rotation !== 3'(i) || busy !== 1'b1)
        $display("FAIL pass_seq%0d: rot %0d busy %b, required %0d 1", i, rotation, busy, i);
      else pass_cnt++;
      if (i == 1) begin
        chk_cnt++;
        if (calc_in[2*DW-1:0] !== {x_re[1], x_im[1]} || calc_in[8*DW-1:6*DW] !== {x_re[13], x_im[13]})
          $display("FAIL operand_fetch: slot0 %h slot3 %h, required %h %h", calc_in[2*DW-1:0],
                   calc_in[8*DW-1:6*DW], {x_re[1], x_im[1]}, {x_re[13], x_im[13]});
        else pass_cnt++;
      end
      step();
    end
    chk_cnt++;
    if (out_valid !== 1'b1 || rotation !== 3'd0 || busy !== 1'b0 || calc_in !== '0 || in_ready !== 1'b0)
      $display("FAIL unload_idle: out_valid %b rot %0d busy %b in_ready %b calc_in %h, required 1 0 0 0 0",
               out_valid, rotation, busy, in_ready, calc_in);
    else pass_cnt++;
    recv_frame(0);
  endtask

  task automatic test_impulse();
    bf_identity = 1'b0;
    make_impulse();
    send_frame(0);
    recv_frame(0);
    for (int k = 0; k < 16; k++) begin
      chk_cnt++;
      if (r_re[k] !== e_re[k] || r_im[k] !== e_im[k] || r_idx[k] !== 4'(k))
        $display("FAIL impulse_bin%0d: got (%0d,%0d) idx %0d, required (%0d,%0d) idx %0d",
                 k, r_re[k], r_im[k], r_idx[k], e_re[k], e_im[k], k);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    bf_identity = 1'b1;
    for (int n = 0; n < 16; n++) begin
      x_re[n] = 17'(200 + 7*n);
      x_im[n] = 17'(n) - 17'd3;
    end
    make_perm_expect();
    send_frame(2);
    recv_frame(1);
    for (int k = 0; k < 16; k++) begin
      chk_cnt++;
      if (r_re[k] !== e_re[k] || r_im[k] !== e_im[k] || r_idx[k] !== 4'(k))
        $display("FAIL bp_bin%0d: got (%0d,%0d) idx %0d, required (%0d,%0d) idx %0d",
                 k, r_re[k], r_im[k], r_idx[k], e_re[k], e_im[k], k);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    bf_identity = 1'b0;
    make_impulse();
    send_frame(0);
    repeat (5) step();
    chk_cnt++;
    if (busy !== 1'b1 || rotation !== 3'd5)
      $display("FAIL mid_stage2: busy %b rot %0d, required 1 5", busy, rotation);
    else pass_cnt++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_abort: in_ready %b out_valid %b busy %b, required 1 0 0", in_ready, out_valid, busy);
    else pass_cnt++;
    send_frame(0);
    recv_frame(0);
    for (int k = 0; k < 16; k += 5) begin
      chk_cnt++;
      if (r_re[k] !== e_re[k] || r_im[k] !== e_im[k])
        $display("FAIL after_reset_bin%0d: got (%0d,%0d), required (%0d,%0d)", k, r_re[k], r_im[k], e_re[k], e_im[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    bf_identity = 1'b1;
    for (int n = 0; n < 16; n++) begin
      x_re[n] = 17'(3*n + 1);
      x_im[n] = 17'(n) - 17'd8;
    end
    make_perm_expect();
    send_frame(0);
    recv_frame(0);
    chk_cnt++;
    if (in_ready !== 1'b1) $display("FAIL b2b_ready: in_ready %b, required 1", in_ready);
    else pass_cnt++;
    for (int k = 0; k < 16; k++) begin
      chk_cnt++;
      if (r_re[k] !== e_re[k] || r_im[k] !== e_im[k])
        $display("FAIL b2b_a_bin%0d: got (%0d,%0d), required (%0d,%0d)", k, r_re[k], r_im[k], e_re[k], e_im[k]);
      else pass_cnt++;
    end
    bf_identity = 1'b0;
    make_impulse();
    send_frame(0);
    recv_frame(0);
    chk_cnt++;
    if (first_cyc - acc_cyc !== 8)
      $display("FAIL b2b_latency: got %0d edges, required 8", first_cyc - acc_cyc);
    else pass_cnt++;
    for (int k = 0; k < 16; k++) begin
      chk_cnt++;
      if (r_re[k] !== e_re[k] || r_im[k] !== e_im[k] || r_idx[k] !== 4'(k))
        $display("FAIL b2b_b_bin%0d: got (%0d,%0d) idx %0d, required (%0d,%0d) idx %0d",
                 k, r_re[k], r_im[k], r_idx[k], e_re[k], e_im[k], k);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_permutation();
    test_passes();
    test_impulse();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
